// File: rtl/chu_sampler_fifo_core.sv
// ---------------------------------------------------------------------------
// chu_sampler_fifo_core
//
// Multi-channel sampler slot core. At a programmable tick rate, all N_CH
// channel inputs are snapshotted together, and then pushed into an internal
// FIFO one channel per cycle. The FIFO head is read and popped over the
// slot bus. Capture runs either continuously or as a triggered burst.
//
// Ports
//   clk       system clock
//   reset     asynchronous active-low reset
//   cs        slot select
//   read      slot read strobe (reads have no side effects)
//   write     slot write strobe
//   addr      register address
//   wr_data   write data
//   rd_data   read data, combinational from addr
//   din       channel inputs, channel k = din[k*W +: W]
//   ext_trig  external trigger (rising edge is used)
//   irq       level interrupt: done, or FIFO count at/above threshold
//
// Register map
//   0 W CTRL   {clear[4], ovw[3], trig_src[2], mode[1], en[0]}
//   0 R STATUS {count[31:16], state[5:4], done[3], overflow[2], full[1], empty[0]}
//   1 RW       prescale P
//   2 RW       {threshold[31:16], burst_len[15:0]}
//   3 W/R      software trigger / FIFO head {valid, ch_id[30:28], sample}
//   4 W        pop
//   5 W        {clr_done[1], clr_overflow[0]}
// ---------------------------------------------------------------------------
module chu_sampler_fifo_core #(
    parameter int N_CH      = 4,
    parameter int W         = 12,
    parameter int DEPTH_BIT = 6,
    parameter int PRESC_W   = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              read,
    input  logic              write,
    input  logic [4:0]        addr,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    input  logic [N_CH*W-1:0] din,
    input  logic              ext_trig,
    output logic              irq
);

    localparam int DEPTH = 1 << DEPTH_BIT;
    localparam int CW    = DEPTH_BIT + 1;   // count spans 0..DEPTH
    localparam int EW    = 3 + W;           // {ch_id, sample}

    // Smallest terminal count: one tick must leave room for a full scan.
    localparam logic [PRESC_W-1:0] MIN_TERM = PRESC_W'(N_CH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        SCAN  = 2'd3
    } state_t;

    // Bus decodes
    logic wr_en, ctrl_wr, clr, trig_wr, pop_wr, flag_wr;
    assign wr_en   = cs & write;
    assign ctrl_wr = wr_en && (addr == 5'd0);
    assign clr     = ctrl_wr & wr_data[4];
    assign trig_wr = wr_en && (addr == 5'd3);
    assign pop_wr  = wr_en && (addr == 5'd4);
    assign flag_wr = wr_en && (addr == 5'd5);

    // The read strobe carries no side effects in this slot.
    logic unused_read;
    assign unused_read = read;

    // Configuration registers
    logic               en, mode, trig_src, ovw;
    logic [PRESC_W-1:0] presc;
    logic [15:0]        burst_len, thresh;
    logic               ext_trig_d;

    // Sequencer state
    state_t             state;
    logic [PRESC_W-1:0] cnt;
    logic [15:0]        burst_cnt;
    logic [2:0]         idx;
    logic [N_CH*W-1:0]  snap;
    logic               done;

    // FIFO
    logic [EW-1:0]        mem [DEPTH];
    logic [DEPTH_BIT-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0]        count;
    logic                 overflow;

    // -----------------------------------------------------------------------
    // Configuration registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en         <= 1'b0;
            mode       <= 1'b0;
            trig_src   <= 1'b0;
            ovw        <= 1'b0;
            presc      <= '0;
            burst_len  <= '0;
            thresh     <= '0;
            ext_trig_d <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                en       <= wr_data[0];
                mode     <= wr_data[1];
                trig_src <= wr_data[2];
                ovw      <= wr_data[3];
            end
            if (wr_en && addr == 5'd1) presc <= wr_data[PRESC_W-1:0];
            if (wr_en && addr == 5'd2) begin
                burst_len <= wr_data[15:0];
                thresh    <= wr_data[31:16];
            end
            ext_trig_d <= ext_trig;
        end
    end

    // -----------------------------------------------------------------------
    // Sequencer
    // -----------------------------------------------------------------------
    logic [PRESC_W-1:0] term;
    logic [15:0]        len_eff;
    logic               tick, last_ch, trig, stop;

    assign term    = (presc > MIN_TERM) ? presc : MIN_TERM;
    assign tick    = (state == RUN || state == SCAN) && (cnt >= term);
    assign last_ch = (idx == 3'(N_CH - 1));
    assign len_eff = (burst_len == 16'd0) ? 16'd1 : burst_len;
    assign trig    = trig_src ? (ext_trig & ~ext_trig_d) : trig_wr;
    // A CTRL write with en=0 aborts in the same cycle it lands.
    assign stop    = ctrl_wr ? ~wr_data[0] : ~en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            burst_cnt <= '0;
            idx       <= '0;
            snap      <= '0;
            done      <= 1'b0;
        end else begin
            if (flag_wr && wr_data[1]) done <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    // Leaving IDLE needs an explicit CTRL write, so a finished
                    // burst stays parked even though en is still set.
                    if (ctrl_wr && wr_data[0]) begin
                        state     <= wr_data[1] ? ARMED : RUN;
                        burst_cnt <= '0;
                        idx       <= '0;
                    end
                end
                ARMED: begin
                    cnt <= '0;
                    if (trig) state <= RUN;
                end
                RUN: begin
                    cnt <= tick ? '0 : cnt + PRESC_W'(1);
                    if (tick) begin
                        snap      <= din;
                        idx       <= '0;
                        burst_cnt <= burst_cnt + 16'd1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    cnt <= tick ? '0 : cnt + PRESC_W'(1);
                    if (last_ch) begin
                        if (mode && burst_cnt >= len_eff) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else if (tick) begin
                            // Minimum period: next tick lands on the last scan
                            // cycle, so rescan back-to-back.
                            snap      <= din;
                            idx       <= '0;
                            burst_cnt <= burst_cnt + 16'd1;
                        end else begin
                            state <= RUN;
                        end
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
            endcase

            if (stop) state <= IDLE;

            if (clr) begin
                cnt       <= '0;
                burst_cnt <= '0;
                done      <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // FIFO
    // -----------------------------------------------------------------------
    logic [W-1:0] cur_sample;
    logic         empty, full, push, pop, mem_we;

    // NOTE: every always_comb output gets a default first so no latch forms.
    always_comb begin
        cur_sample = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (idx == 3'(k)) cur_sample = snap[k*W +: W];
        end
    end

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign push   = (state == SCAN);
    assign pop    = pop_wr && !empty;
    // On a full FIFO the write proceeds only if a slot is freed by a pop or
    // by dropping the oldest entry.
    assign mem_we = push && !clr && (!full || pop || ovw);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (flag_wr && wr_data[0]) overflow <= 1'b0;
            if (push && full && !pop)  overflow <= 1'b1;
            if (mem_we) wr_ptr <= wr_ptr + DEPTH_BIT'(1);
            if (pop || (push && full && ovw)) rd_ptr <= rd_ptr + DEPTH_BIT'(1);
            if (push && !pop && !full)   count <= count + CW'(1);
            else if (pop && !push)       count <= count - CW'(1);
        end
    end

    // NOTE: the storage array has no reset; pointers and count alone decide
    // which entries are valid.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr] <= {idx, cur_sample};
    end

    // -----------------------------------------------------------------------
    // Read mux and interrupt
    // -----------------------------------------------------------------------
    logic [EW-1:0] head;
    assign head = mem[rd_ptr];

    always_comb begin
        rd_data = '0;
        case (addr)
            5'd0: begin
                rd_data[31:16] = 16'(count);
                rd_data[5:4]   = state;
                rd_data[3]     = done;
                rd_data[2]     = overflow;
                rd_data[1]     = full;
                rd_data[0]     = empty;
            end
            5'd1: rd_data = 32'(presc);
            5'd2: rd_data = {thresh, burst_len};
            5'd3: begin
                if (!empty) begin
                    rd_data[31]    = 1'b1;
                    rd_data[30:28] = head[EW-1 -: 3];
                    rd_data[W-1:0] = head[W-1:0];
                end
            end
            default: rd_data = '0;
        endcase
    end

    assign irq = done | ((thresh != 16'd0) && (16'(count) >= thresh));

endmodule

// File: tb/tb_chu_sampler_fifo_core.sv
// ---------------------------------------------------------------------------
// tb_chu_sampler_fifo_core
//
// Directed bench for the sampler slot. Inputs change just after the falling
// edge and outputs are sampled in the low phase, so every bus write lands on
// the next rising edge. Comments of the form "edge k" count rising edges
// from the write that started the current scenario.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_chu_sampler_fifo_core;

    localparam int N_CH      = 4;
    localparam int W         = 12;
    localparam int DEPTH_BIT = 4;    // 16 entries
    localparam int PRESC_W   = 24;

    logic              clk      = 1'b0;
    logic              reset    = 1'b0;
    logic              cs       = 1'b0;
    logic              read     = 1'b0;
    logic              write    = 1'b0;
    logic [4:0]        addr     = '0;
    logic [31:0]       wr_data  = '0;
    logic [31:0]       rd_data;
    logic [N_CH*W-1:0] din      = '0;
    logic              ext_trig = 1'b0;
    logic              irq;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    chu_sampler_fifo_core #(
        .N_CH     (N_CH),
        .W        (W),
        .DEPTH_BIT(DEPTH_BIT),
        .PRESC_W  (PRESC_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .din     (din),
        .ext_trig(ext_trig),
        .irq     (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; the write lands on the next rising edge.
    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        cs      = 1'b1;
        write   = 1'b1;
        addr    = a;
        wr_data = d;
        @(negedge clk);
        cs      = 1'b0;
        write   = 1'b0;
        wr_data = '0;
    endtask

    task automatic check_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
        addr = a;
        read = 1'b1;
        #1;
        check(tag, rd_data, exp);
        read = 1'b0;
    endtask

    task automatic check_irq(input string tag, input logic exp);
        check(tag, {31'd0, irq}, {31'd0, exp});
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        din = {12'h333, 12'h222, 12'h111, 12'h000};

        // ---------------- Reset ----------------
        wait_cycles(5);
        reset = 1'b1;
        check_reg("rst_status", 5'd0, 32'h0000_0001);
        check_irq("rst_irq", 1'b0);
        check_reg("rst_head", 5'd3, 32'h0000_0000);
        check_reg("rst_unused", 5'd7, 32'h0000_0000);

        // ---------------- Continuous, P=9 ----------------
        bus_write(5'd1, 32'd9);
        check_reg("presc_rb", 5'd1, 32'd9);
        bus_write(5'd0, 32'h1);            // edge 1: RUN, cnt 0
        wait_cycles(10);                   // edge 11: first tick -> SCAN
        check_reg("cont_tick1", 5'd0, 32'h0000_0031);
        wait_cycles(1);                    // edge 12: ch0 pushed
        check_reg("cont_cnt1", 5'd0, 32'h0001_0030);
        check_reg("cont_head0", 5'd3, 32'h8000_0000);
        wait_cycles(3);                    // edge 15: ch3 pushed, back to RUN
        check_reg("cont_cnt4", 5'd0, 32'h0004_0020);
        bus_write(5'd4, 32'h0);            // pop ch0
        check_reg("cont_pop1", 5'd0, 32'h0003_0020);
        check_reg("cont_head1", 5'd3, 32'h9000_0111);
        bus_write(5'd4, 32'h0);            // edge 17: pop ch1
        check_reg("cont_head2", 5'd3, 32'hA000_0222);
        wait_cycles(3);                    // edge 20: still counting
        check_reg("cont_run", 5'd0, 32'h0002_0020);
        wait_cycles(1);                    // edge 21: second tick, 10 after the first
        check_reg("cont_tick2", 5'd0, 32'h0002_0030);
        wait_cycles(4);                    // edge 25: 4 more entries
        check_reg("cont_cnt6", 5'd0, 32'h0006_0020);
        bus_write(5'd0, 32'h10);           // clear + disable
        check_reg("cont_clear", 5'd0, 32'h0000_0001);

        // ---------------- Period clamp P=0, fill, simultaneous, ovw=0 ----------------
        bus_write(5'd1, 32'd0);
        bus_write(5'd0, 32'h1);            // edge 1: RUN
        wait_cycles(4);                    // edge 5: tick (period clamped to 4)
        check_reg("clamp_tick", 5'd0, 32'h0000_0031);
        wait_cycles(4);                    // edge 9: 4 entries, rescan
        check_reg("clamp_4", 5'd0, 32'h0004_0030);
        wait_cycles(4);                    // edge 13
        check_reg("clamp_8", 5'd0, 32'h0008_0030);
        wait_cycles(8);                    // edge 21: full
        check_reg("clamp_full", 5'd0, 32'h0010_0032);
        bus_write(5'd4, 32'h0);            // edge 22: pop alongside push at full
        check_reg("simul_status", 5'd0, 32'h0010_0032);
        check_reg("simul_head", 5'd3, 32'h9000_0111);
        wait_cycles(1);                    // edge 23: push onto full, dropped
        check_reg("ovf0_status", 5'd0, 32'h0010_0036);
        check_reg("ovf0_head", 5'd3, 32'h9000_0111);
        bus_write(5'd0, 32'h0);            // stop, FIFO kept
        check_reg("stop_status", 5'd0, 32'h0010_0006);
        bus_write(5'd5, 32'h1);            // clear overflow
        check_reg("ovf_clr", 5'd0, 32'h0010_0002);

        // ---------------- Overflow, ovw=1 ----------------
        bus_write(5'd0, 32'h9);            // edge 1: RUN with drop-oldest
        wait_cycles(5);                    // edge 6: one push, oldest dropped
        check_reg("ovw_1_status", 5'd0, 32'h0010_0036);
        check_reg("ovw_1_head", 5'd3, 32'hA000_0222);
        wait_cycles(3);                    // edge 9: four drops in total
        check_reg("ovw_4_status", 5'd0, 32'h0010_0036);
        check_reg("ovw_4_head", 5'd3, 32'h9000_0111);
        bus_write(5'd0, 32'h10);
        check_reg("ovw_clear", 5'd0, 32'h0000_0001);

        // ---------------- Burst with ext_trig, L=3, P=15 ----------------
        bus_write(5'd1, 32'd15);
        bus_write(5'd2, 32'h0000_0003);
        bus_write(5'd0, 32'h7);            // en, burst, ext trigger
        check_reg("burst_armed", 5'd0, 32'h0000_0011);
        check_irq("burst_irq0", 1'b0);
        bus_write(5'd3, 32'h0);            // software trigger ignored in ext mode
        wait_cycles(3);
        check_reg("burst_still_armed", 5'd0, 32'h0000_0011);
        ext_trig = 1'b1;
        wait_cycles(1);                    // edge 1: rising edge seen -> RUN
        check_reg("burst_run", 5'd0, 32'h0000_0021);
        wait_cycles(51);                   // edge 52: 11 entries, last scan
        check_reg("burst_11", 5'd0, 32'h000B_0030);
        wait_cycles(1);                    // edge 53: 12 entries, done, IDLE
        check_reg("burst_done", 5'd0, 32'h000C_0008);
        check_irq("burst_irq_done", 1'b1);
        ext_trig = 1'b0;
        wait_cycles(2);
        ext_trig = 1'b1;
        wait_cycles(30);
        ext_trig = 1'b0;
        check_reg("burst_retrig", 5'd0, 32'h000C_0008);

        // ---------------- Threshold interrupt ----------------
        bus_write(5'd5, 32'h2);            // clear done
        check_reg("done_clr", 5'd0, 32'h000C_0000);
        check_irq("irq_no_thresh", 1'b0);
        bus_write(5'd2, {16'd12, 16'd3});
        check_reg("thresh_rb", 5'd2, 32'h000C_0003);
        check_irq("irq_at_thresh", 1'b1);
        bus_write(5'd2, {16'd13, 16'd3});
        check_irq("irq_below_thresh", 1'b0);
        bus_write(5'd0, 32'h10);
        check_reg("burst_clear", 5'd0, 32'h0000_0001);

        // ---------------- Abort during second scan cycle ----------------
        bus_write(5'd1, 32'd9);
        bus_write(5'd2, 32'h0);
        bus_write(5'd0, 32'h1);            // edge 1: RUN
        wait_cycles(11);                   // edge 12: ch0 pushed, 2nd scan cycle
        check_reg("abort_pre", 5'd0, 32'h0001_0030);
        bus_write(5'd0, 32'h0);            // edge 13: ch1 pushed, then IDLE
        check_reg("abort_post", 5'd0, 32'h0002_0000);
        wait_cycles(3);
        check_reg("abort_hold", 5'd0, 32'h0002_0000);
        check_reg("abort_head", 5'd3, 32'h8000_0000);
        bus_write(5'd4, 32'h0);
        check_reg("abort_head1", 5'd3, 32'h9000_0111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/chu_sampler_fifo_core.md
Name: chu_sampler_fifo_core

Overview:
- Parametrised multi-channel sampler slot core for the MMIO subsystem; generalises the single user FIFO slot.
- Snapshots N_CH parallel W-bit channel inputs at a programmable rate into an internal FIFO.
- Supports continuous and triggered-burst capture, selectable overflow policy and a threshold interrupt.
- Sits in one MMIO slot behind the slot bus (cs/read/write/addr/rd_data/wr_data).

Parameters:
N_CH, 4, channels captured per sample tick (1..8)
W, 12, bits per channel sample (1..16)
DEPTH_BIT, 6, FIFO holds 2**DEPTH_BIT entries
PRESC_W, 24, prescale register width

Ports:
clk  in  1  system clock; sole clock
reset  in  1  asynchronous, active-low reset
cs  in  1  slot select
read  in  1  slot read strobe
write  in  1  slot write strobe
addr  in  5  register address
wr_data  in  32  write data
rd_data  out  32  read data, combinational from addr
din  in  N_CH*W  channel inputs, channel k = din[k*W +: W], synchronous to clk
ext_trig  in  1  external trigger, synchronous to clk
irq  out  1  level interrupt

Behaviour:
- Register writes take effect when cs&write; pop takes effect when cs&write at addr 4. No other side effects on read.
- addr0 W CTRL:
  - bit0 en; bit1 mode (0 continuous, 1 burst); bit2 trig_src (0 software, 1 ext_trig rising edge); bit3 ovw (0 drop newest, 1 drop oldest).
  - bit4 clear: self-clearing; flushes FIFO, prescale counter, burst counter, overflow and done flags in the same cycle.
- addr0 R STATUS:
  - bit0 empty, bit1 full, bit2 overflow (sticky), bit3 done (sticky), bits[5:4] state code.
  - [31:16] entry count, 0..2**DEPTH_BIT.
- addr1 RW: prescale P[PRESC_W-1:0]. Effective tick period = max(P+1, N_CH) cycles.
- addr2 RW: [15:0] burst length L (0 treated as 1); [31:16] threshold T.
- addr3 W: software trigger (any write). addr3 R: FIFO head as {valid[31], ch_id[30:28], zeros, sample[W-1:0]}; reads 0 when empty.
- addr4 W: pop. Pop when empty is ignored.
- addr5 W: bit0 = 1 clears overflow; bit1 = 1 clears done.
- Unused addresses read 0.
- FSM states:
  - IDLE(0): entered on reset or en=0.
  - ARMED(1): mode=1 and en=1, waiting for the selected trigger.
  - RUN(2): prescale counting.
  - SCAN(3): pushing snapshot entries.
- FSM transitions:
  - IDLE -> RUN when en=1 and mode=0; IDLE -> ARMED when en=1 and mode=1.
  - In RUN the counter counts up each cycle; on reaching the effective period-1 it wraps to 0 and issues a tick. The tick latches all N_CH channels into a snapshot register in that cycle and moves to SCAN.
  - SCAN pushes channel 0..N_CH-1, one entry per cycle, for N_CH cycles. The prescale counter keeps running. Then return to RUN.
  - Burst mode: the burst counter increments per tick. After the L-th tick's scan completes, set done and go to IDLE. The core stays in IDLE while en is still 1; re-arm requires a CTRL write with en=1.
  - Triggers are ignored outside ARMED. An ext_trig rising edge is detected with a 1-cycle delay register.
- Writing CTRL with en=0 mid-SCAN aborts immediately. Entries already pushed remain; remaining channels are not pushed.
- Push onto full FIFO:
  - ovw=0: new entry discarded; overflow set.
  - ovw=1: head dropped and new entry written in the same cycle; count unchanged; overflow set.
- Simultaneous push and bus pop: both occur; count unchanged. This holds on a full FIFO as well, with no overflow.
- Clear in the same cycle as a push or pop: clear wins.
- irq = done | (T != 0 & count >= T); combinational from registered state.
- Reset values: FIFO empty, all registers 0, state IDLE, irq 0, rd_data follows mux, which gives STATUS = 0x0000_0001 at addr0.
- Latency: first entry is visible at addr3 on the cycle after the first SCAN cycle. Snapshot is coherent across channels within one tick.

Test Plan:
- Reset: hold reset low 5 cycles -> STATUS reads 0x0000_0001, irq 0, addr3 reads 0.
- Continuous: N_CH=4, W=12, P=9, din={12'h333,12'h222,12'h111,12'h000}, en=1 -> after 10 cycles, 4 entries appear ch0..ch3. Head reads 0x8000_0000, then 0x9000_0111 after pop. Ticks occur every 10 cycles.
- Period clamp: P=0 -> ticks every 4 cycles; count grows by exactly 4 per 4 cycles until full.
- Burst with ext_trig: mode=1, trig_src=1, L=3, P=15 -> state ARMED until ext_trig rises. Then exactly 12 entries; done=1, irq=1, state IDLE. A second ext_trig pulse adds nothing.
- Overflow: DEPTH_BIT=3, fill 8 entries. With ovw=0, the next tick leaves count 8 and head unchanged, overflow=1. Repeat with ovw=1: head advances by 4 entries, count 8.
- Simultaneous and abort: pop on the same cycle as a push at full -> count stays 8, overflow stays 0. Writing en=0 during the 2nd SCAN cycle -> exactly 2 entries added from that tick; state IDLE.
